irq_coalesce_ctrl: RTL and testbench

IRQ_COALESCE_CTRL -- requirements
Module: irq_coalesce_ctrl

---
 rtl/irq_coalesce_ctrl.sv | 150 +++++++++++++++
 tb/tb_irq_coalesce_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_coalesce_ctrl.sv
// Interrupt coalescing controller: batches event strobes into one interrupt.
// Latency: an event seen in IDLE raises irq two cycles later when the effective threshold is 1.
// Backpressure: none; the host clears irq with irq_ack, after which a holdoff window starts.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_en              enable; when low, new events are ignored
//   cfg_pkt_thresh      pending count that fires (0 behaves as 1)
//   cfg_timeout         ARMED cycles before a forced fire
//   cfg_holdoff         minimum extra HOLDOFF cycles after an ack
//   evt                 single-cycle event strobe
//   irq, irq_ack        interrupt level and host acknowledge
//   irq_cause           bit0 threshold, bit1 timeout (latched at fire)
//   batch_cnt           pending count captured at fire
//   pend_cnt            live pending-event count
//   irq_total, evt_drop statistics counters, present only with IRQ_COALESCE_STATS_EN
//
// Optional feature macro: IRQ_COALESCE_STATS_EN
module irq_coalesce_ctrl #(
  parameter int CNT_W = 16,
  parameter int TMO_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_pkt_thresh,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic [TMO_W-1:0] cfg_holdoff,
  input  logic             evt,
  output logic             irq,
  input  logic             irq_ack,
  output logic [1:0]       irq_cause,
  output logic [CNT_W-1:0] batch_cnt,
`ifdef IRQ_COALESCE_STATS_EN
  output logic [31:0]      irq_total,
  output logic [31:0]      evt_drop,
`endif
  output logic [CNT_W-1:0] pend_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] ASSERT  = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_MAX = '1;
  localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [TMO_W-1:0] tmr;
  logic [TMO_W-1:0] hold;

  logic             evt_ok;
  logic [CNT_W:0]   pend_sum;
  logic [CNT_W-1:0] pend_inc;
  logic [CNT_W-1:0] eff_thresh;
  logic             thr_hit;
  logic             tmo_hit;
  logic             fire;
  logic             sat_drop;
  logic [TMO_W-1:0] tmr_inc;
  logic [TMO_W-1:0] hold_inc;

  always_comb begin
    evt_ok     = evt & cfg_en;
    // One extra bit so the threshold compare sees the true sum even at saturation.
    pend_sum   = {1'b0, pend_cnt} + {{CNT_W{1'b0}}, evt_ok};
    pend_inc   = pend_sum[CNT_W] ? CNT_MAX : pend_sum[CNT_W-1:0];
    eff_thresh = (cfg_pkt_thresh == '0) ? CNT_ONE : cfg_pkt_thresh;
    thr_hit    = pend_sum >= {1'b0, eff_thresh};
    tmo_hit    = tmr >= cfg_timeout;
    fire       = (state == ARMED) && cfg_en && (thr_hit || tmo_hit);
    // An accepted event that cannot be added because the counter is full is lost.
    sat_drop   = evt_ok && (pend_cnt == CNT_MAX) && (state != IDLE);
    tmr_inc    = (tmr == TMO_MAX) ? tmr : tmr + TMO_ONE;
    hold_inc   = (hold == TMO_MAX) ? hold : hold + TMO_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq       <= 1'b0;
      irq_cause <= 2'b00;
      batch_cnt <= '0;
      pend_cnt  <= '0;
      tmr       <= '0;
      hold      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (evt_ok) begin
            state    <= ARMED;
            pend_cnt <= CNT_ONE;
            tmr      <= '0;
          end
        end
        ARMED: begin
          if (!cfg_en) begin
            // Disabling abandons the partial batch; nothing has been signalled yet.
            state    <= IDLE;
            pend_cnt <= '0;
          end else if (fire) begin
            state     <= ASSERT;
            irq       <= 1'b1;
            irq_cause <= {tmo_hit, thr_hit};
            batch_cnt <= pend_inc;
            pend_cnt  <= '0;
          end else begin
            pend_cnt <= pend_inc;
            tmr      <= tmr_inc;
          end
        end
        ASSERT: begin
          // Events arriving while the host is servicing form the next batch.
          pend_cnt <= pend_inc;
          if (irq_ack) begin
            state <= HOLDOFF;
            irq   <= 1'b0;
            hold  <= '0;
          end
        end
        HOLDOFF: begin
          pend_cnt <= pend_inc;
          if (hold >= cfg_holdoff) begin
            state <= (pend_inc != '0) ? ARMED : IDLE;
            tmr   <= '0;
          end else begin
            hold <= hold_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IRQ_COALESCE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_total <= '0;
      evt_drop  <= '0;
    end else begin
      if (fire) irq_total <= irq_total + 32'd1;
      if ((evt && !cfg_en) || sat_drop) evt_drop <= evt_drop + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_irq_coalesce_ctrl.sv
// Self-checking bench for irq_coalesce_ctrl: a table of per-cycle vectors followed
// by hand-written multi-cycle sequences (timeout, holdoff length, disable, reset, saturation).
// Counters are built 8 bits wide here so saturation is reached in a few hundred cycles.
module tb_irq_coalesce_ctrl;
  localparam int CW = 8;
  localparam int TW = 32;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_en;
  logic [CW-1:0] cfg_pkt_thresh;
  logic [TW-1:0] cfg_timeout;
  logic [TW-1:0] cfg_holdoff;
  logic          evt;
  logic          irq;
  logic          irq_ack;
  logic [1:0]    irq_cause;
  logic [CW-1:0] batch_cnt;
  logic [CW-1:0] pend_cnt;
`ifdef IRQ_COALESCE_STATS_EN
  logic [31:0]   irq_total;
  logic [31:0]   evt_drop;
`endif

  int checks = 0;
  int failures = 0;

  irq_coalesce_ctrl #(.CNT_W(CW), .TMO_W(TW)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_pkt_thresh(cfg_pkt_thresh),
    .cfg_timeout(cfg_timeout), .cfg_holdoff(cfg_holdoff), .evt(evt),
    .irq(irq), .irq_ack(irq_ack), .irq_cause(irq_cause), .batch_cnt(batch_cnt),
`ifdef IRQ_COALESCE_STATS_EN
    .irq_total(irq_total), .evt_drop(evt_drop),
`endif
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          en;
    logic          evt;
    logic          ack;
    logic [CW-1:0] thresh;
    logic [TW-1:0] tmo;
    logic [TW-1:0] hold;
    logic          e_irq;
    logic [1:0]    e_cause;
    logic [CW-1:0] e_batch;
    logic [CW-1:0] e_pend;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic en, input logic e, input logic a,
                     input logic [CW-1:0] th, input logic [TW-1:0] to, input logic [TW-1:0] ho,
                     input logic ei, input logic [1:0] ec, input logic [CW-1:0] eb,
                     input logic [CW-1:0] ep);
    vec_t v;
    v.rst = r; v.en = en; v.evt = e; v.ack = a; v.thresh = th; v.tmo = to; v.hold = ho;
    v.e_irq = ei; v.e_cause = ec; v.e_batch = eb; v.e_pend = ep;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [31:0] drop0;
    rst = 1'b1; cfg_en = 1'b0; cfg_pkt_thresh = '0; cfg_timeout = '0;
    cfg_holdoff = '0; evt = 1'b0; irq_ack = 1'b0;
    drop0 = '0;
    #1;

    //   rst en evt ack thr  tmo   hold  irq cause batch pend
    add(1, 0, 0, 0, 4, 1000, 0,   0, 0, 0, 0);  // reset state
    add(0, 1, 0, 0, 4, 1000, 0,   0, 0, 0, 0);
    add(0, 1, 1, 0, 4, 1000, 0,   0, 0, 0, 1);  // IDLE -> ARMED
    add(0, 1, 1, 0, 4, 1000, 0,   0, 0, 0, 2);
    add(0, 1, 1, 0, 4, 1000, 0,   0, 0, 0, 3);
    add(0, 1, 1, 0, 4, 1000, 0,   1, 1, 4, 0);  // 4th event fires, counted in batch
    add(0, 1, 0, 0, 4, 1000, 0,   1, 1, 4, 0);  // irq held without ack
    add(0, 1, 1, 0, 4, 1000, 0,   1, 1, 4, 1);  // counted during ASSERT
    add(0, 1, 0, 1, 4, 1000, 0,   0, 1, 4, 1);  // ack drops irq
    add(0, 1, 0, 0, 4, 1000, 0,   0, 1, 4, 1);  // one HOLDOFF cycle -> ARMED
    add(0, 1, 1, 0, 4, 1000, 0,   0, 1, 4, 2);
    add(0, 1, 1, 0, 4, 1000, 0,   0, 1, 4, 3);
    add(0, 1, 1, 0, 4, 1000, 0,   1, 1, 4, 0);  // second batch fires
    add(0, 1, 0, 1, 4, 1000, 0,   0, 1, 4, 0);
    add(0, 1, 0, 0, 4, 1000, 0,   0, 1, 4, 0);  // HOLDOFF -> IDLE
    add(0, 1, 0, 1, 4, 1000, 0,   0, 1, 4, 0);  // ack with irq low ignored
    add(0, 1, 1, 0, 0, 1000, 0,   0, 1, 4, 1);  // thresh 0 behaves as 1
    add(0, 1, 0, 0, 0, 1000, 0,   1, 1, 1, 0);  // irq two cycles after evt
    add(0, 1, 0, 1, 0, 1000, 0,   0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 1000, 0,   0, 1, 1, 0);  // holdoff 0, no events -> IDLE
    add(0, 0, 1, 0, 0, 1000, 0,   0, 1, 1, 0);  // disabled: event ignored
    add(0, 1, 1, 0, 2, 0,    0,   0, 1, 1, 1);
    add(0, 1, 1, 0, 2, 0,    0,   1, 3, 2, 0);  // threshold and timeout together
    add(0, 1, 0, 1, 2, 0,    0,   0, 3, 2, 0);
    add(0, 1, 0, 0, 2, 0,    0,   0, 3, 2, 0);  // cause/batch held

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; cfg_en = tbl[i].en; evt = tbl[i].evt; irq_ack = tbl[i].ack;
      cfg_pkt_thresh = tbl[i].thresh; cfg_timeout = tbl[i].tmo; cfg_holdoff = tbl[i].hold;
      tick();
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].e_irq});
      chk($sformatf("vec%0d_cause", i), {30'd0, irq_cause}, {30'd0, tbl[i].e_cause});
      chk($sformatf("vec%0d_batch", i), {24'd0, batch_cnt}, {24'd0, tbl[i].e_batch});
      chk($sformatf("vec%0d_pend", i), {24'd0, pend_cnt}, {24'd0, tbl[i].e_pend});
    end
    evt = 1'b0; irq_ack = 1'b0;

    // Timeout fire: ARMED entered with tmr=0, compare true when tmr=20 -> 21 edges later.
    rst = 1'b1; tick(); rst = 1'b0;
    cfg_en = 1'b1; cfg_pkt_thresh = 8'd100; cfg_timeout = 32'd20; cfg_holdoff = '0;
    evt = 1'b1; tick(); evt = 1'b0;
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (irq) begin n = k; break; end
    end
    chk("tmo_latency", n, 21);
    chk("tmo_cause", {30'd0, irq_cause}, 32'd2);
    chk("tmo_batch", {24'd0, batch_cnt}, 32'd1);

    // Three events while asserted, holdoff 10 -> 11 HOLDOFF cycles, then ARMED with 3.
    cfg_timeout = 32'd1000; cfg_holdoff = 32'd10;
    evt = 1'b1; tick(); tick(); tick(); evt = 1'b0;
    chk("assert_pend", {24'd0, pend_cnt}, 32'd3);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("ack_irq_low", {31'd0, irq}, 32'd0);
    chk("ack_state", {30'd0, dut.state}, {30'd0, S_HOLDOFF});
    n = 1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (dut.state == S_HOLDOFF) n++;
      else break;
    end
    chk("holdoff_cycles", n, 11);
    chk("holdoff_exit_state", {30'd0, dut.state}, {30'd0, S_ARMED});
    chk("holdoff_exit_pend", {24'd0, pend_cnt}, 32'd3);
    chk("holdoff_exit_tmr", dut.tmr, 32'd0);

    // Disable while ARMED with two pending.
    rst = 1'b1; tick(); rst = 1'b0;
    cfg_en = 1'b1; cfg_pkt_thresh = 8'd100; cfg_timeout = 32'd1000; cfg_holdoff = '0;
    evt = 1'b1; tick(); tick(); evt = 1'b0;
    chk("dis_pend_before", {24'd0, pend_cnt}, 32'd2);
    cfg_en = 1'b0; tick();
    chk("dis_state", {30'd0, dut.state}, {30'd0, S_IDLE});
    chk("dis_pend", {24'd0, pend_cnt}, 32'd0);
    tick();
    chk("dis_irq", {31'd0, irq}, 32'd0);

    // Reset during ASSERT drops irq without an ack.
    cfg_en = 1'b1; cfg_pkt_thresh = 8'd1;
    evt = 1'b1; tick(); evt = 1'b0; tick();
    chk("rst_pre_irq", {31'd0, irq}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_state", {30'd0, dut.state}, {30'd0, S_IDLE});

    // Saturation: 255 events fire the batch, then 260 more while asserted.
    cfg_pkt_thresh = 8'hFF; cfg_timeout = 32'hFFFF_FFFF;
    evt = 1'b1;
    for (int k = 0; k < 255; k++) tick();
    chk("sat_fire_irq", {31'd0, irq}, 32'd1);
    chk("sat_fire_batch", {24'd0, batch_cnt}, 32'd255);
`ifdef IRQ_COALESCE_STATS_EN
    drop0 = evt_drop;
    chk("stat_total", irq_total, 32'd1);
`endif
    for (int k = 0; k < 260; k++) tick();
    evt = 1'b0;
    chk("sat_pend", {24'd0, pend_cnt}, 32'd255);
    chk("sat_irq_held", {31'd0, irq}, 32'd1);
`ifdef IRQ_COALESCE_STATS_EN
    chk("sat_drop_delta", evt_drop - drop0, 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
